// File: rtl/mem_access_pkg.sv
// mem_access shared definitions:
// FSM states, timeout default, legal byte-enable patterns.
`ifndef DataCatchDepth
`define DataCatchDepth 16
`endif

package mem_access_pkg;

  localparam int DATA_CATCH_DEPTH = `DataCatchDepth;
  localparam int TIMEOUT_DEF      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_HL = 4'b0011;
  localparam logic [3:0] BE_HH = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    return be inside {BE_B0, BE_B1, BE_B2, BE_B3,
                      BE_HL, BE_HH, BE_W};
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: masks read data to the enabled lanes
// and shifts the lowest enabled lane down to bit 0.
module load_align (
  input  logic [3:0]  i_be,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] w_mask;
  logic [31:0] w_masked;
  logic [4:0]  w_shift;

  assign w_mask = {{8{i_be[3]}}, {8{i_be[2]}},
                   {8{i_be[1]}}, {8{i_be[0]}}};
  assign w_masked = i_rdata & w_mask;

  // shift amount from the lowest set enable bit
  always_comb begin
    w_shift = 5'd0;
    priority case (1'b1)
      i_be[0]: w_shift = 5'd0;
      i_be[1]: w_shift = 5'd8;
      i_be[2]: w_shift = 5'd16;
      i_be[3]: w_shift = 5'd24;
      default: w_shift = 5'd0;
    endcase
  end

  assign o_data = w_masked >> w_shift;

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage; passes ALU results through,
// runs one data-memory transaction at a time with timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int AW      = DATA_CATCH_DEPTH,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_vld,
  input  logic [4:0]    ex_rd_idx,
  input  logic [31:0]   x_rd,
  input  logic          x_rd_vld,
  input  logic [AW-1:0] MEMaddr,
  input  logic [3:0]    MEMrden,
  input  logic [3:0]    MEMwren,
  input  logic [31:0]   MEMwrdata,
  output logic          dm_req,
  output logic          dm_we,
  output logic [3:0]    dm_be,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  input  logic [31:0]   dm_rdata,
  output logic          wb_vld,
  output logic [4:0]    wb_idx,
  output logic [31:0]   wb_data,
  output logic          stall,
  output logic          error
);

  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);
  localparam logic [AW-1:0] ADDR_MASK =
    {{(AW-2){1'b1}}, 2'b00};

  state_e      r_state;
  logic [4:0]  r_cnt;
  logic [4:0]  r_rd_idx;
  logic        r_rd_vld;

  logic        w_rd_op;
  logic        w_wr_op;
  logic [3:0]  w_be;
  logic [31:0] w_load;

  assign w_rd_op = |MEMrden;
  assign w_wr_op = |MEMwren;
  assign w_be    = w_wr_op ? MEMwren : MEMrden;
  assign stall   = (r_state == BUSY);

  load_align u_align (
    .i_be    (dm_be),
    .i_rdata (dm_rdata),
    .o_data  (w_load)
  );

  // transaction FSM with registered memory and write-back outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rd_idx <= '0;
      r_rd_vld <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_be    <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      wb_vld   <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
      error    <= 1'b0;
    end else begin
      wb_vld <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (ex_vld) begin
            if (w_rd_op && w_wr_op) begin
              error <= 1'b1;
            end else if (w_rd_op || w_wr_op) begin
              if (!be_legal(w_be)) begin
                error <= 1'b1;
              end else begin
                dm_req   <= 1'b1;
                dm_we    <= w_wr_op;
                dm_be    <= w_be;
                dm_addr  <= MEMaddr & ADDR_MASK;
                dm_wdata <= MEMwrdata;
                r_rd_idx <= ex_rd_idx;
                r_rd_vld <= x_rd_vld;
                r_cnt    <= '0;
                r_state  <= BUSY;
              end
            end else begin
              wb_vld  <= x_rd_vld;
              wb_idx  <= ex_rd_idx;
              wb_data <= x_rd;
            end
          end
        end
        BUSY: begin
          if (dm_ack) begin
            dm_req  <= 1'b0;
            r_state <= IDLE;
            if (!dm_we) begin
              wb_vld  <= r_rd_vld;
              wb_idx  <= r_rd_idx;
              wb_data <= w_load;
            end
          end else if (r_cnt == TO_LAST) begin
            error   <= 1'b1;
            dm_req  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors, write-backs checked
// by a queue-based scoreboard monitor.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int AW = DATA_CATCH_DEPTH;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_vld = 1'b0;
  logic [4:0]    ex_rd_idx = '0;
  logic [31:0]   x_rd = '0;
  logic          x_rd_vld = 1'b0;
  logic [AW-1:0] MEMaddr = '0;
  logic [3:0]    MEMrden = '0;
  logic [3:0]    MEMwren = '0;
  logic [31:0]   MEMwrdata = '0;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack = 1'b0;
  logic [31:0]   dm_rdata = '0;
  logic          wb_vld;
  logic [4:0]    wb_idx;
  logic [31:0]   wb_data;
  logic          stall;
  logic          error;

  int  n_checks = 0;
  int  n_fail   = 0;
  wb_t exp_q[$];
  logic snap_req;
  int  stalls;

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .ex_vld    (ex_vld),
    .ex_rd_idx (ex_rd_idx),
    .x_rd      (x_rd),
    .x_rd_vld  (x_rd_vld),
    .MEMaddr   (MEMaddr),
    .MEMrden   (MEMrden),
    .MEMwren   (MEMwren),
    .MEMwrdata (MEMwrdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .wb_vld    (wb_vld),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .stall     (stall),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  // scoreboard monitor: every write-back pops one expectation
  always @(negedge clk) begin
    if (!rst && wb_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb_vld", 32'(wb_vld), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_idx", 32'(wb_idx), 32'(e.idx));
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic clear_in();
    ex_vld    = 1'b0;
    x_rd_vld  = 1'b0;
    MEMrden   = '0;
    MEMwren   = '0;
    MEMaddr   = '0;
    MEMwrdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // issue a memory op at a negedge; ack after 'waits' busy cycles
  // (waits < 0 means never ack); leaves caller at a negedge
  task automatic mem_op(input logic [3:0] rden,
                        input logic [3:0] wren,
                        input logic [AW-1:0] addr,
                        input logic [31:0] wdata,
                        input logic [4:0] idx,
                        input int waits,
                        input int max_cyc,
                        input logic [31:0] rdata);
    ex_vld    = 1'b1;
    x_rd_vld  = 1'b1;
    ex_rd_idx = idx;
    x_rd      = 32'h5555_5555;
    MEMrden   = rden;
    MEMwren   = wren;
    MEMaddr   = addr;
    MEMwrdata = wdata;
    @(negedge clk);
    clear_in();
    snap_req = dm_req;
    stalls = 0;
    for (int k = 0; k < max_cyc; k++) begin
      if (stall) stalls++;
      dm_ack   = (k == waits);
      dm_rdata = (k == waits) ? rdata : 32'h0BAD_F00D;
      @(negedge clk);
      dm_ack = 1'b0;
      if (k == waits) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_dm_req", 32'(dm_req), 0);
    chk("rst_wb_vld", 32'(wb_vld), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_stall", 32'(stall), 0);
    rst = 1'b0;

    // ALU pass-through
    ex_vld = 1'b1; x_rd = 32'h1234_5678;
    x_rd_vld = 1'b1; ex_rd_idx = 5'd5;
    exp_q.push_back('{5'd5, 32'h1234_5678});
    @(negedge clk);
    clear_in();
    chk("alu_stall", 32'(stall), 0);
    chk("alu_wb_vld", 32'(wb_vld), 1);

    // LW, ack 3 cycles after request
    exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
    mem_op(4'b1111, 4'b0000, AW'(16'h40), 32'h0,
           5'd7, 3, 8, 32'hDEAD_BEEF);
    chk("lw_req", 32'(snap_req), 1);
    chk("lw_stall_cycles", stalls, 4);
    chk("lw_dm_addr", 32'(dm_addr), 32'h40);
    chk("lw_dm_we", 32'(dm_we), 0);
    chk("lw_dm_req_off", 32'(dm_req), 0);
    chk("lw_stall_off", 32'(stall), 0);

    // byte load, lane 2
    exp_q.push_back('{5'd9, 32'h0000_00BB});
    mem_op(4'b0100, 4'b0000, AW'(16'h42), 32'h0,
           5'd9, 1, 8, 32'hAABB_CCDD);
    chk("lb_be", 32'(dm_be), 32'h4);

    // halfword load, upper half
    exp_q.push_back('{5'd10, 32'h0000_AABB});
    mem_op(4'b1100, 4'b0000, AW'(16'h46), 32'h0,
           5'd10, 0, 8, 32'hAABB_CCDD);

    // SW, unaligned address gets word-aligned, no write-back
    mem_op(4'b0000, 4'b1111, AW'(16'h83), 32'hCAFE_F00D,
           5'd11, 0, 8, 32'h0);
    chk("sw_req", 32'(snap_req), 1);
    chk("sw_dm_addr", 32'(dm_addr), 32'h80);
    chk("sw_dm_we", 32'(dm_we), 1);
    chk("sw_dm_wdata", dm_wdata, 32'hCAFE_F00D);
    @(negedge clk);

    // ack on the last allowed cycle still succeeds
    exp_q.push_back('{5'd12, 32'h0000_0021});
    mem_op(4'b0001, 4'b0000, AW'(16'h10), 32'h0,
           5'd12, 15, 20, 32'h4321_4321);
    chk("ackwin_stall_cycles", stalls, 16);
    chk("ackwin_error", 32'(error), 0);

    // timeout: no ack at all
    mem_op(4'b1111, 4'b0000, AW'(16'h20), 32'h0,
           5'd13, -1, 16, 32'h0);
    chk("to_stall_cycles", stalls, 16);
    chk("to_error", 32'(error), 1);
    chk("to_dm_req", 32'(dm_req), 0);
    chk("to_stall", 32'(stall), 0);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("idle_ack_stall", 32'(stall), 0);
    do_reset();
    chk("to_rst_error", 32'(error), 0);

    // read and write enables together
    mem_op(4'b1111, 4'b0001, AW'(16'h30), 32'h0,
           5'd14, -1, 3, 32'h0);
    chk("both_req", 32'(snap_req), 0);
    chk("both_dm_req", 32'(dm_req), 0);
    chk("both_error", 32'(error), 1);
    do_reset();

    // non-contiguous byte enables
    mem_op(4'b0101, 4'b0000, AW'(16'h30), 32'h0,
           5'd15, -1, 3, 32'h0);
    chk("ncont_req", 32'(snap_req), 0);
    chk("ncont_error", 32'(error), 1);
    do_reset();

    // reset during BUSY, late ack ignored
    mem_op(4'b1111, 4'b0000, AW'(16'h50), 32'h0,
           5'd16, -1, 1, 32'h0);
    chk("rb_req", 32'(snap_req), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dm_ack = 1'b1;
    dm_rdata = 32'h1111_2222;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("rb_stall", 32'(stall), 0);
    chk("rb_dm_req", 32'(dm_req), 0);
    @(negedge clk);
    @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 The parameter AW SHALL default to `DataCatchDepth and sets the data-memory address width.
REQ-003 The parameter TIMEOUT SHALL default to 16 and sets the maximum wait for dm_ack, in cycles.
REQ-004 The ports SHALL be, one per line:
 clk  in  1  clock
 rst  in  1  sync reset, active-high
 ex_vld  in  1  execute-stage result valid this cycle
 ex_rd_idx  in  5  destination register index
 x_rd  in  32  ALU result from execute
 x_rd_vld  in  1  destination write requested
 MEMaddr  in  AW  data-memory byte address
 MEMrden  in  4  load byte enables
 MEMwren  in  4  store byte enables
 MEMwrdata  in  32  store data, already lane-aligned
 dm_req  out  1  data-memory request
 dm_we  out  1  1 = write, 0 = read
 dm_be  out  4  byte enables
 dm_addr  out  AW  word-aligned address (low 2 bits forced 0)
 dm_wdata  out  32  write data
 dm_ack  in  1  memory completion strobe
 dm_rdata  in  32  read data, valid with dm_ack
 wb_vld  out  1  write-back strobe, one cycle
 wb_idx  out  5  write-back register index
 wb_data  out  32  write-back data
 stall  out  1  upstream must hold its inputs
 error  out  1  sticky fault flag

Function
REQ-005 The FSM SHALL have the states IDLE and BUSY.
REQ-006 In IDLE with ex_vld=1, MEMrden=0 and MEMwren=0, the block SHALL register wb_vld=x_rd_vld, wb_idx=ex_rd_idx and wb_data=x_rd on the next edge (latency 1); stall SHALL stay 0.
REQ-007 In IDLE with ex_vld=1 and exactly one of MEMrden or MEMwren nonzero, the block SHALL on the next edge assert dm_req, drive dm_we/dm_be/dm_addr/dm_wdata from the inputs, latch ex_rd_idx and x_rd_vld, and enter BUSY.
REQ-008 stall SHALL be combinational: 1 in BUSY, else 0; upstream inputs SHALL be ignored while stall=1.
REQ-009 In BUSY, dm_req and all dm_* outputs SHALL hold stable until the dm_ack cycle; on dm_ack the block SHALL deassert dm_req at the next edge and return to IDLE.
REQ-010 On a load ack, the block SHALL set wb_vld = latched x_rd_vld and wb_data = (dm_rdata AND byte mask of dm_be) shifted right by 8 × (index of the lowest set bit of dm_be), zero-extended.
REQ-011 On a store ack, wb_vld SHALL be 0.
REQ-012 A 5-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without dm_ack; when it reaches TIMEOUT-1 without ack, the block SHALL set error, drop dm_req and return to IDLE with wb_vld=0.
REQ-013 dm_ack arriving in the same cycle the counter hits TIMEOUT-1 SHALL count as success (ack wins).
REQ-014 dm_ack in IDLE SHALL be ignored.
REQ-015 ex_vld with both MEMrden and MEMwren nonzero SHALL set error, issue no request, and produce wb_vld=0.
REQ-016 A non-contiguous byte-enable pattern (not 0001/0010/0100/1000/0011/1100/1111) SHALL set error, issue no request, and produce wb_vld=0.
REQ-017 wb_vld SHALL be a single-cycle pulse; wb_idx and wb_data SHALL hold their last values otherwise.
REQ-018 error SHALL be sticky until rst.

Reset
REQ-019 On rst=1 at a clk edge, the state SHALL become IDLE and dm_req, dm_we, dm_be, dm_addr, dm_wdata, wb_vld, wb_idx, wb_data, error and the wait counter SHALL all be 0.
REQ-020 A reset asserted in BUSY SHALL abandon the transaction with no write-back, and any dm_ack in the following cycle SHALL be ignored.

Structure
REQ-021 The FSM state encodings, the TIMEOUT default and the legal byte-enable patterns SHALL be defined in defines.v alongside the existing instruction IDs.
REQ-022 The load-lane extraction logic SHALL be a sub-module named load_align.

Verification
REQ-023 The bench SHALL cover: ALU pass-through, ex_vld=1, x_rd=0x12345678, x_rd_vld=1, ex_rd_idx=5 -> next cycle wb_vld=1, wb_idx=5, wb_data=0x12345678, stall=0.
REQ-024 The bench SHALL cover: LW, MEMaddr=0x40, MEMrden=1111, dm_ack 3 cycles later with dm_rdata=0xDEADBEEF -> stall=1 for 4 cycles, then wb_data=0xDEADBEEF.
REQ-025 The bench SHALL cover: byte load, MEMrden=0100, dm_rdata=0xAABBCCDD -> wb_data=0x000000BB.
REQ-026 The bench SHALL cover: SW, MEMwren=1111, MEMwrdata=0xCAFEF00D, addr=0x83 -> dm_addr=0x80, dm_we=1, dm_wdata=0xCAFEF00D, no wb_vld after ack.
REQ-027 The bench SHALL cover: no dm_ack for 16 cycles -> error=1, dm_req=0, state IDLE; then rst -> error=0.
REQ-028 The bench SHALL cover: MEMrden=1111 and MEMwren=0001 together -> error=1, dm_req never asserted.
